framebuffer_1bpp: RTL
=====================

# framebuffer_1bpp

Monochrome 1-bit-per-pixel frame store feeding the SSD1309 driver's framebuffer read interface. It holds a WIDTH×HEIGHT image in page-major order (byte = 8 vertical pixels, bit 0 topmost), the same layout the panel's RAM uses. Content producers write single pixels or bulk-clear. The display driver reads 8-pixel column slices (native panel byte) or 8-pixel horizontal runs through a level-held request / valid handshake.

## Interface
- WIDTH, 128, pixels per row; ≤256.
- HEIGHT, 64, pixel rows; multiple of 8, ≤256.
- clk  in  1  system clock (27 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- fb_w_xpos  in  8  write pixel x.
- fb_w_ypos  in  8  write pixel y.
- fb_w_data  in  1  pixel value to write (1 = lit).
- fb_we  in  1  write request, sampled only when idle.
- fb_clear  in  1  clear-all request, sampled only when idle.
- fb_r_xpos  in  8  read start x.
- fb_r_ypos  in  8  read start y.
- fb_r_mode  in  1  0 = horizontal run, 1 = column slice.
- fb_re  in  1  read request, level-held by reader.
- fb_dout  out  8  read result.
- fb_data_valid  out  1  fb_dout valid.
- fb_busy  out  1  engine occupied; new requests not accepted.

## Operation
- Storage: WIDTH*HEIGHT/8 bytes in single-port synchronous RAM (1-cycle read latency), address = (y>>3)*WIDTH + x. RAM contents are not reset.
- FSM states: IDLE, WR_FETCH, WR_STORE, CLEAR, RD_COL, RD_HORZ, VALID.
- Arbitration in IDLE, same cycle: fb_clear > fb_we > fb_re. A losing request is not latched. fb_we/fb_clear are single-cycle accepts; the requester re-issues if fb_busy was high.
- Pixel write: IDLE→WR_FETCH (read byte)→WR_STORE (set/clear bit y[2:0], write back)→IDLE. Out-of-range x≥WIDTH or y≥HEIGHT: the sequence runs but the RAM write is suppressed.
- Clear: CLEAR writes 0x00 to addresses 0..N-1, one per cycle, then returns to IDLE.
- Read, mode 1 (column): bit k of fb_dout = pixel(x, y+k).
  - y aligned to 8: one RAM read.
  - Unaligned: reads pages y>>3 and (y>>3)+1, then funnel-shifts.
- Read, mode 0 (horizontal): bit 7-k of fb_dout = pixel(x+k, y) (MSB leftmost). Eight RAM reads are issued back-to-back.
- Any pixel outside the image reads as 0, including page overflow and x+k≥WIDTH.
- Read addresses and mode are captured on the accept cycle. Later changes are ignored until the next accept.
- VALID: fb_data_valid=1 and fb_dout held stable while fb_re=1. When fb_re=0 in VALID: fb_data_valid clears next cycle and the FSM goes to IDLE.
- A new read is accepted only from IDLE. The reader must drop fb_re for ≥1 cycle between reads.

## Timing
- Reset values: fb_dout=0, fb_data_valid=0, fb_busy=0, FSM=IDLE, all address/counter registers 0.
- reset_n assertion mid-operation aborts immediately. A partial clear or write leaves RAM partially updated. No RAM write occurs while reset_n=0.
- fb_busy is registered. It is high from the cycle after accept until the cycle the FSM re-enters IDLE. It is low in IDLE and VALID.
- Latency from accept cycle T (fb_re high in IDLE) to fb_data_valid high:
  - Aligned column: T+2.
  - Unaligned column: T+3.
  - Horizontal: T+9.
- Pixel write: accept T, RAM write at T+2, IDLE (fb_busy low) at T+3. A read accepted at T+3 sees the new value.
- Clear: accept T, writes at T+1..T+N, IDLE at T+N+1 (N=1024 default).
- fb_re may rise in the same cycle the reader changes addresses. The driver sets addresses one cycle early, which is also legal.

## Configuration
- FRAMEBUFFER_CLEAR_EN defined: clear engine and CLEAR state present, behaving as above.
- FRAMEBUFFER_CLEAR_EN undefined: fb_clear is ignored, the CLEAR state and its counter are not synthesized, and fb_we becomes top priority.

## Test plan
- Aligned column read: write pixels (5,8),(5,10),(5,15)=1, then column read x=5,y=8 → fb_dout=0x85, fb_data_valid at T+2, held until fb_re drops, cleared the cycle after.
- Unaligned column read across pages: lit (3,6),(3,9); column read x=3,y=6 → 0x09 at T+3. Column read y=60 with (0,63) lit → 0x08; bits 4-7 read 0 (beyond image).
- Horizontal run with clipping: lit (120,2),(127,2); horizontal read x=120,y=2 → 0x81 at T+9. Read x=125,y=2 → 0x20.
- Read-after-write ordering: write (0,0)=1; assert fb_re the cycle fb_busy falls → reads 0x01. Write (0,0)=0 → 0x00. Write (200,0)=1 → RAM unchanged.
- Clear with macro defined: fill pattern, pulse fb_clear → fb_busy high for 1024 cycles, all reads return 0x00. fb_we pulsed during busy is dropped. Macro undefined: fb_clear has no effect.
- Async reset mid-clear at cycle 100: outputs all 0 immediately, FSM IDLE after release, addresses ≥100 retain the old pattern.

Source files
------------

// File: rtl/framebuffer_1bpp.sv
// framebuffer_1bpp: page-major 1bpp frame store with pixel write, column/row reads.
// Optional bulk clear engine enabled by defining FRAMEBUFFER_CLEAR_EN.
module framebuffer_1bpp #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] fb_w_xpos,
  input  logic [7:0] fb_w_ypos,
  input  logic       fb_w_data,
  input  logic       fb_we,
  input  logic       fb_clear,
  input  logic [7:0] fb_r_xpos,
  input  logic [7:0] fb_r_ypos,
  input  logic       fb_r_mode,
  input  logic       fb_re,
  output logic [7:0] fb_dout,
  output logic       fb_data_valid,
  output logic       fb_busy
);

  localparam int N  = WIDTH * HEIGHT / 8;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_STORE,
    RD_COL,
    RD_HORZ,
    VALID
`ifdef FRAMEBUFFER_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        wdat_q, wdat_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q;
  logic        busy_q;

  logic [7:0]  mem [N];
  logic [7:0]  rdata;
  logic [AW-1:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;

  logic [5:0]  pg;
  logic [8:0]  xa;
  logic        x_ok;
  logic        wr_ok;
  logic [7:0]  wbyte;
  logic [15:0] funnel;
  logic [7:0]  colmask;
  logic [7:0]  colbyte;
  logic        hbit;

`ifdef FRAMEBUFFER_CLEAR_EN
  logic [AW-1:0] clr_q, clr_d;
`else
  logic unused_clear;
  assign unused_clear = fb_clear;
`endif

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata <= mem[ram_addr];
  end

  always_comb begin
    x_ok  = 32'(x_q) < WIDTH;
    wr_ok = x_ok && (32'(y_q) < HEIGHT);
    wbyte = rdata;
    wbyte[y_q[2:0]] = wdat_q;
    funnel = {rdata, lo_q} >> y_q[2:0];
    for (int k = 0; k < 8; k++)
      colmask[k] = x_ok && ((32'(y_q) + k) < HEIGHT);
    colbyte = ((y_q[2:0] == 3'd0) ? rdata : funnel[7:0]) & colmask;
    hbit = rdata[y_q[2:0]]
        && ((32'(x_q) + 32'(cnt_q)) < WIDTH)
        && (32'(y_q) < HEIGHT);
  end

  // In IDLE the RAM is addressed straight from the read inputs so
  // the first byte is already in flight on the accept cycle.
  always_comb begin
    pg        = {1'b0, y_q[7:3]};
    xa        = {1'b0, x_q};
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    unique case (state_q)
      IDLE: begin
        pg = {1'b0, fb_r_ypos[7:3]};
        xa = {1'b0, fb_r_xpos};
      end
      RD_COL:  pg = {1'b0, y_q[7:3]} + 6'd1;
      RD_HORZ: xa = {1'b0, x_q} + {6'd0, cnt_q} + 9'd1;
      WR_STORE: begin
        ram_we    = wr_ok;
        ram_wdata = wbyte;
      end
      default: ;
    endcase
    ram_addr = AW'(32'(pg) * WIDTH + 32'(xa));
`ifdef FRAMEBUFFER_CLEAR_EN
    if (state_q == CLEAR) begin
      ram_addr = clr_q;
      ram_we   = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
`ifdef FRAMEBUFFER_CLEAR_EN
    clr_d   = clr_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef FRAMEBUFFER_CLEAR_EN
        if (fb_clear) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else
`endif
        if (fb_we) begin
          state_d = WR_FETCH;
          x_d     = fb_w_xpos;
          y_d     = fb_w_ypos;
          wdat_d  = fb_w_data;
        end else if (fb_re) begin
          state_d = fb_r_mode ? RD_COL : RD_HORZ;
          x_d     = fb_r_xpos;
          y_d     = fb_r_ypos;
          cnt_d   = 3'd0;
          sh_d    = 8'h00;
        end
      end
      WR_FETCH: state_d = WR_STORE;
      WR_STORE: state_d = IDLE;
      RD_COL: begin
        if (y_q[2:0] != 3'd0 && cnt_q == 3'd0) begin
          lo_d  = rdata;
          cnt_d = 3'd1;
        end else begin
          dout_d  = colbyte;
          state_d = VALID;
        end
      end
      RD_HORZ: begin
        sh_d  = {sh_q[6:0], hbit};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          dout_d  = {sh_q[6:0], hbit};
          state_d = VALID;
        end
      end
      VALID: if (!fb_re) state_d = IDLE;
`ifdef FRAMEBUFFER_CLEAR_EN
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == AW'(N - 1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      wdat_q  <= 1'b0;
      cnt_q   <= 3'd0;
      lo_q    <= 8'h00;
      sh_q    <= 8'h00;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FRAMEBUFFER_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= (state_d == VALID);
      busy_q  <= (state_d != IDLE) && (state_d != VALID);
`ifdef FRAMEBUFFER_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  assign fb_dout       = dout_q;
  assign fb_data_valid = valid_q;
  assign fb_busy       = busy_q;

endmodule
